// File: rtl/memory_access_if.sv
// Bundle of the XM (execute/memory) inputs and the MW (memory/writeback) outputs of the memory stage.
interface memory_access_if;
  logic        XM_MemtoReg;
  logic        XM_RegWrite;
  logic        XM_MemRead;
  logic        XM_MemWrite;
  logic        XM_branch;
  logic [31:0] ALUout;
  logic [4:0]  XM_RD;
  logic [31:0] XM_MD;
  logic [31:0] XM_BT;
  logic        MW_MemtoReg;
  logic        MW_RegWrite;
  logic [31:0] MW_ALUout;
  logic [31:0] MW_MDR;
  logic [4:0]  MW_RD;
  logic        PCSrc;
  logic [31:0] PC_target;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
           ALUout, XM_RD, XM_MD, XM_BT,
    input  MW_MemtoReg, MW_RegWrite, MW_ALUout, MW_MDR, MW_RD,
           PCSrc, PC_target, mem_stall, mem_err
  );

  modport slave (
    input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
           ALUout, XM_RD, XM_MD, XM_BT,
    output MW_MemtoReg, MW_RegWrite, MW_ALUout, MW_MDR, MW_RD,
           PCSrc, PC_target, mem_stall, mem_err
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage: 128-word internal data memory, two-cycle loads with a one-cycle stall,
// single-cycle stores, misaligned-access trap and branch redirect.
//
// state     | meaning
// IDLE      | accept new instruction; an aligned load stalls and inserts a bubble
// LOAD_WAIT | read memory for the held load and write the MW stage
module memory_access (
  input logic             clk,
  input logic             rst,
  memory_access_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mem [0:127];
  logic        r_memtoreg;
  logic        r_regwrite;
  logic [31:0] r_aluout;
  logic [31:0] r_mdr;
  logic [4:0]  r_rd;
  logic        r_err;
  logic [6:0]  w_idx;
  logic        w_mis;
  logic        w_store;
  logic        w_load;
  logic        w_stall;
  logic        w_unused;

  assign w_idx    = bus.ALUout[8:2];
  assign w_unused = &{1'b0, bus.ALUout[31:9]};
  assign w_mis    = (bus.ALUout[1:0] != 2'b00) && (bus.XM_MemRead || bus.XM_MemWrite);
  assign w_store  = bus.XM_MemWrite && !w_mis;
  assign w_load   = bus.XM_MemRead && !bus.XM_MemWrite && !w_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_stall = 1'b1;
          w_next  = LOAD_WAIT;
        end
      end
      LOAD_WAIT: w_next = IDLE;
    endcase
  end

  // Array is deliberately unreset so contents survive a pipeline reset
  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_idx] <= bus.XM_MD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_aluout   <= 32'h0;
      r_mdr      <= 32'h0;
      r_rd       <= 5'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_mis) r_err <= 1'b1;
      if (w_stall) begin
        r_memtoreg <= 1'b0;
        r_regwrite <= 1'b0;
      end else begin
        r_memtoreg <= bus.XM_MemtoReg;
        r_regwrite <= bus.XM_RegWrite && !w_mis;
        r_aluout   <= bus.ALUout;
        r_rd       <= bus.XM_RD;
        if (r_state == LOAD_WAIT) r_mdr <= r_mem[w_idx];
      end
    end
  end

  assign bus.MW_MemtoReg = r_memtoreg;
  assign bus.MW_RegWrite = r_regwrite;
  assign bus.MW_ALUout   = r_aluout;
  assign bus.MW_MDR      = r_mdr;
  assign bus.MW_RD       = r_rd;
  assign bus.mem_stall   = w_stall;
  assign bus.mem_err     = r_err;
  assign bus.PCSrc       = bus.XM_branch && !w_stall;
  assign bus.PC_target   = bus.XM_BT;
endmodule
